// File: rtl/cpu_fetch_ctrl.sv
// rtl/cpu_fetch_ctrl.sv - MiniCPU fetch/decode/execute controller driving a combinational ROM.
// Optional HALT opcode (1111) is enabled by defining MINICPU_HALT_EN.
module cpu_fetch_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  output logic [AW-1:0] o_addr,
  input  logic [7:0]    i_instr,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_valid,
  output logic [DW-1:0] o_reg_a,
  output logic          o_carry,
  output logic          o_halted
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
`ifdef MINICPU_HALT_EN
    ,ST_HALT  = 2'd3
`endif
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_STB  = 4'b1000;
  localparam logic [3:0] OP_STA  = 4'b1100;
`ifdef MINICPU_HALT_EN
  localparam logic [3:0] OP_HALT = 4'b1111;
`endif

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_ir;
  logic [3:0]    r_op;
  logic [3:0]    r_imm;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic          r_carry;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;

  logic          w_ir_load;
  logic          w_decode;
  logic          w_exec;
  logic [DW-1:0] w_imm_ext;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;

  assign w_imm_ext = {{(DW-4){1'b0}}, r_imm};
  // The extra top bit of the widened difference is the borrow (A < B).
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ir_load    = 1'b0;
    w_decode     = 1'b0;
    w_exec       = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (i_run) begin
          w_ir_load    = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_decode     = 1'b1;
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_exec       = 1'b1;
        w_next_state = ST_FETCH;
`ifdef MINICPU_HALT_EN
        if (r_op == OP_HALT) begin
          w_next_state = ST_HALT;
        end
`endif
      end
`ifdef MINICPU_HALT_EN
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
`endif
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_op        <= '0;
      r_imm       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_ir_load) begin
        r_ir <= i_instr;
      end
      if (w_decode) begin
        r_op  <= r_ir[7:4];
        r_imm <= r_ir[3:0];
        r_pc  <= r_pc + AW'(1);
      end
      if (w_exec) begin
        case (r_op)
          OP_LDA: r_a <= w_imm_ext;
          OP_LDB: r_b <= w_imm_ext;
          OP_ADD: begin
            r_a     <= w_sum[DW-1:0];
            r_carry <= w_sum[DW];
          end
          OP_SUB: begin
            r_a     <= w_diff[DW-1:0];
            r_carry <= w_diff[DW];
          end
          OP_OR:  r_a <= r_a | r_b;
          OP_AND: r_a <= r_a & r_b;
          OP_STA: begin
            r_out_data  <= r_a;
            r_out_valid <= 1'b1;
          end
          OP_STB: begin
            r_out_data  <= r_b;
            r_out_valid <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_addr      = r_pc;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_reg_a     = r_a;
  assign o_carry     = r_carry;
`ifdef MINICPU_HALT_EN
  assign o_halted    = (r_state == ST_HALT);
`else
  assign o_halted    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// tb/tb_cpu_fetch_ctrl.sv - self-checking bench for cpu_fetch_ctrl with an instruction-level model.
// Honours MINICPU_HALT_EN in the halt scenario.
module tb_cpu_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] addr;
  logic [7:0] instr;
  logic [7:0] out_data;
  logic       out_valid;
  logic [7:0] reg_a;
  logic       carry;
  logic       halted;

  logic [7:0] rom [16];
  int errors = 0;
  int checks = 0;

  int m_a, m_b, m_c, m_out, m_pc;

  assign instr = rom[addr];

  always #5 clk = ~clk;

  cpu_fetch_ctrl #(.AW(4), .DW(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .o_addr(addr), .i_instr(instr),
    .o_out_data(out_data), .o_out_valid(out_valid), .o_reg_a(reg_a),
    .o_carry(carry), .o_halted(halted)
  );

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_directed();
    logic [7:0] prog [12];
    prog = '{8'h13, 8'h25, 8'h40, 8'hC0, 8'h12, 8'h25, 8'h60, 8'h80,
             8'h14, 8'h21, 8'h70, 8'hC0};
    for (int i = 0; i < 16; i++) rom[i] = (i < 12) ? prog[i] : 8'h00;
  endtask

  task automatic test_reset();
    load_directed();
    rst = 1'b1;
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (addr !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (reg_a !== 8'h00) begin errors++; $display("FAIL reset_reg_a: got %h want 00", reg_a); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_directed_program();
    logic exp_v;
    load_directed();
    do_reset();
    run = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      exp_v = (cyc == 12 || cyc == 24 || cyc == 36);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL dir_valid c%0d: got %b want %b", cyc, out_valid, exp_v); end
      if (cyc == 2) begin
        checks++; if (addr !== 4'h1) begin errors++; $display("FAIL dir_addr_c2: got %h want 1", addr); end
      end
      if (cyc == 12) begin
        checks++; if (out_data !== 8'h08) begin errors++; $display("FAIL dir_out_c12: got %h want 08", out_data); end
        checks++; if (reg_a !== 8'h08) begin errors++; $display("FAIL dir_a_c12: got %h want 08", reg_a); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL dir_carry_c12: got %b want 0", carry); end
      end
      if (cyc == 21) begin
        checks++; if (reg_a !== 8'hFD) begin errors++; $display("FAIL dir_a_c21: got %h want FD", reg_a); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL dir_carry_c21: got %b want 1", carry); end
      end
      if (cyc == 24) begin
        checks++; if (out_data !== 8'h05) begin errors++; $display("FAIL dir_out_c24: got %h want 05", out_data); end
      end
      if (cyc == 36) begin
        checks++; if (out_data !== 8'h05) begin errors++; $display("FAIL dir_out_c36: got %h want 05", out_data); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL dir_carry_c36: got %b want 1", carry); end
      end
      if (cyc == 48) begin
        checks++; if (addr !== 4'h0) begin errors++; $display("FAIL dir_wrap_c48: got %h want 0", addr); end
      end
      next_cycle();
    end
  endtask

  task automatic test_run_stall();
    logic exp_v;
    load_directed();
    do_reset();
    for (int cyc = 0; cyc < 45; cyc++) begin
      run = (cyc >= 5);
      @(negedge clk);
      exp_v = (cyc == 17 || cyc == 29 || cyc == 41);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stall_valid c%0d: got %b want %b", cyc, out_valid, exp_v); end
      if (cyc == 6) begin
        checks++; if (addr !== 4'h0) begin errors++; $display("FAIL stall_addr_c6: got %h want 0", addr); end
      end
      if (cyc == 7) begin
        checks++; if (addr !== 4'h1) begin errors++; $display("FAIL stall_addr_c7: got %h want 1", addr); end
      end
      if (cyc == 17) begin
        checks++; if (out_data !== 8'h08) begin errors++; $display("FAIL stall_out_c17: got %h want 08", out_data); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_abort();
    logic exp_v;
    load_directed();
    do_reset();
    run = 1'b1;
    for (int cyc = 0; cyc < 23; cyc++) begin
      rst = (cyc == 8);
      @(negedge clk);
      if (cyc == 8) begin
        checks++; if (addr !== 4'h3) begin errors++; $display("FAIL abort_addr_c8: got %h want 3", addr); end
      end
      if (cyc == 9) begin
        checks++; if (reg_a !== 8'h00) begin errors++; $display("FAIL abort_a: got %h want 00", reg_a); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL abort_carry: got %b want 0", carry); end
        checks++; if (addr !== 4'h0) begin errors++; $display("FAIL abort_addr: got %h want 0", addr); end
      end
      if (cyc >= 9) begin
        exp_v = (cyc == 21);
        checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL abort_valid c%0d: got %b want %b", cyc, out_valid, exp_v); end
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_halt();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h1F;
    rom[1] = 8'hF0;
    do_reset();
    run = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
`ifdef MINICPU_HALT_EN
      if (cyc >= 6) begin
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag c%0d: got %b want 1", cyc, halted); end
        checks++; if (addr !== 4'h2) begin errors++; $display("FAIL halt_addr c%0d: got %h want 2", cyc, addr); end
        checks++; if (reg_a !== 8'h0F) begin errors++; $display("FAIL halt_a c%0d: got %h want 0F", cyc, reg_a); end
      end else begin
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early c%0d: got %b want 0", cyc, halted); end
      end
`else
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nohalt_flag c%0d: got %b want 0", cyc, halted); end
      if (cyc == 48) begin
        checks++; if (addr !== 4'h0) begin errors++; $display("FAIL nohalt_wrap: got %h want 0", addr); end
        checks++; if (reg_a !== 8'h0F) begin errors++; $display("FAIL nohalt_a: got %h want 0F", reg_a); end
      end
`endif
      next_cycle();
    end
  endtask

  task automatic model_step(output int stored);
    int op, imm, s;
    op  = rom[m_pc] >> 4;
    imm = rom[m_pc] % 16;
    stored = 0;
    case (op)
      1:  m_a = imm;
      2:  m_b = imm;
      4:  begin s = m_a + m_b; m_c = (s > 255); m_a = s % 256; end
      6:  begin m_c = (m_a < m_b); m_a = (m_a - m_b + 256) % 256; end
      7:  m_a = m_a | m_b;
      5:  m_a = m_a & m_b;
      12: begin m_out = m_a; stored = 1; end
      8:  begin m_out = m_b; stored = 1; end
      default: ;
    endcase
    m_pc = (m_pc + 1) % 16;
  endtask

  task automatic test_random();
    int stalls, prev_store, st;
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'($urandom);
      if (rom[i][7:4] == 4'hF) rom[i][7:4] = 4'h6;
    end
    m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_pc = 0; prev_store = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      stalls = $urandom_range(0, 3);
      for (int s = 0; s <= stalls; s++) begin
        run = (s == stalls);
        @(negedge clk);
        checks++; if (addr !== 4'(m_pc)) begin errors++; $display("FAIL rnd_fetch_addr k%0d: got %h want %h", k, addr, m_pc); end
        if (s == 0) begin
          checks++; if (out_valid !== 1'(prev_store)) begin errors++; $display("FAIL rnd_valid k%0d: got %b want %0d", k, out_valid, prev_store); end
          checks++; if (reg_a !== 8'(m_a)) begin errors++; $display("FAIL rnd_a k%0d: got %h want %h", k, reg_a, m_a); end
          checks++; if (carry !== 1'(m_c)) begin errors++; $display("FAIL rnd_carry k%0d: got %b want %0d", k, carry, m_c); end
          checks++; if (out_data !== 8'(m_out)) begin errors++; $display("FAIL rnd_out k%0d: got %h want %h", k, out_data, m_out); end
        end else begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_stall_valid k%0d: got %b want 0", k, out_valid); end
        end
        next_cycle();
      end
      run = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (addr !== 4'(m_pc)) begin errors++; $display("FAIL rnd_dec_addr k%0d: got %h want %h", k, addr, m_pc); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_dec_valid k%0d: got %b want 0", k, out_valid); end
      next_cycle();
      run = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (addr !== 4'((m_pc + 1) % 16)) begin errors++; $display("FAIL rnd_exec_addr k%0d: got %h want %h", k, addr, (m_pc + 1) % 16); end
      next_cycle();
      model_step(st);
      prev_store = st;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'(prev_store)) begin errors++; $display("FAIL rnd_last_valid: got %b want %0d", out_valid, prev_store); end
    checks++; if (reg_a !== 8'(m_a)) begin errors++; $display("FAIL rnd_last_a: got %h want %h", reg_a, m_a); end
  endtask

  initial begin
    test_reset();
    test_directed_program();
    test_run_stall();
    test_reset_abort();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
